// File: rtl/port_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// port_bus_master_pkg
// Shared definitions for the hardware port-bus initiator: the sequencer state
// type, default port addresses, the done bit position, the start command and
// the result sentinel returned when polling gives up.
// Optional feature macro: PORT_BUS_MASTER_TIMEOUT_EN (enables poll timeout).
// ---------------------------------------------------------------------------
package port_bus_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_GO,
    S_GAP,
    S_POLL,
    S_RD_MSB,
    S_RD_LSB,
    S_RESP
  } state_e;

  localparam logic [7:0]  DEF_ADDR_A         = 8'h80;
  localparam logic [7:0]  DEF_ADDR_B         = 8'h81;
  localparam logic [7:0]  DEF_ADDR_CTRL      = 8'h82;
  localparam logic [7:0]  DEF_ADDR_IDLE      = 8'h00;
  localparam int unsigned DEF_POLL_GAP       = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1023;

  localparam int          DONE_BIT     = 0;
  localparam logic [7:0]  START_CMD    = 8'h01;
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/port_bus_master_if.sv
// ---------------------------------------------------------------------------
// port_bus_master_if
// The 8-bit port bus shared by the initiator and the multiplier responder.
//   port_id      : bus address
//   out_port     : write data
//   write_strobe : one-cycle write qualifier
//   read_strobe  : one-cycle read qualifier
//   in_port      : read data, combinational from the responder for port_id
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface port_bus_master_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;

  modport master (
    output port_id,
    output out_port,
    output write_strobe,
    output read_strobe,
    input  in_port
  );

  modport slave (
    input  port_id,
    input  out_port,
    input  write_strobe,
    input  read_strobe,
    output in_port
  );
endinterface

// File: rtl/port_bus_master_access.sv
// ---------------------------------------------------------------------------
// port_bus_access
// Registered single-cycle bus driver. The sequencer presents the access it
// wants for the next cycle on {req_addr, req_data, req_rd, req_wr}; this block
// registers it onto the bus so every bus output comes straight from a flop.
// rd_data is the responder's in_port for the access currently on the bus;
// the sequencer samples it at the clock edge that ends that access.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req_addr, req_data   : requested address / write data
//   req_rd, req_wr       : requested read / write (write wins if both)
//   rd_data              : in_port for the current access
//   bus                  : port bus, master side
// ---------------------------------------------------------------------------
module port_bus_access
  import port_bus_master_pkg::*;
#(
  parameter logic [7:0] ADDR_IDLE = DEF_ADDR_IDLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       req_rd,
  input  logic       req_wr,
  output logic [7:0] rd_data,
  port_bus_master_if.master bus
);

  logic [7:0] port_id_d,  port_id_q;
  logic [7:0] out_port_d, out_port_q;
  logic       wr_d,       wr_q;
  logic       rd_d,       rd_q;

  // With no access requested the bus parks at ADDR_IDLE with zero data, so a
  // stale address never lingers where the responder could decode it.
  always_comb begin
    wr_d       = req_wr;
    rd_d       = req_rd && !req_wr;
    port_id_d  = ADDR_IDLE;
    out_port_d = 8'h00;
    if (wr_d || rd_d) begin
      port_id_d = req_addr;
    end
    if (wr_d) begin
      out_port_d = req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_id_q  <= ADDR_IDLE;
      out_port_q <= 8'h00;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      port_id_q  <= port_id_d;
      out_port_q <= out_port_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  assign bus.port_id      = port_id_q;
  assign bus.out_port     = out_port_q;
  assign bus.write_strobe = wr_q;
  assign bus.read_strobe  = rd_q;
  assign rd_data          = bus.in_port;

endmodule

// File: rtl/port_bus_master.sv
// ---------------------------------------------------------------------------
// port_bus_master
// Hardware initiator for the multiplier's port bus. Takes an operand pair on
// the op stream, writes A, B and the start command, polls the done bit with a
// POLL_GAP idle gap before every poll, reads the 16-bit product back
// ({MSB, LSB}) and offers it on the res stream. One operation at a time.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   op_valid/op_ready/op_a/op_b : operand stream
//   res_valid/res_ready/res_data: result stream
//   bus                         : port bus, master side
//   busy                        : high whenever not IDLE
//   timeout_err                 : sticky poll timeout (optional feature only)
// Optional feature macro: PORT_BUS_MASTER_TIMEOUT_EN. When defined, polling
// gives up after TIMEOUT_CYCLES cycles in GAP/POLL and returns 16'hDEAD.
// ---------------------------------------------------------------------------
module port_bus_master
  import port_bus_master_pkg::*;
#(
  parameter logic [7:0]  ADDR_A    = DEF_ADDR_A,
  parameter logic [7:0]  ADDR_B    = DEF_ADDR_B,
  parameter logic [7:0]  ADDR_CTRL = DEF_ADDR_CTRL,
  parameter logic [7:0]  ADDR_IDLE = DEF_ADDR_IDLE,
  parameter int unsigned POLL_GAP  = DEF_POLL_GAP
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  port_bus_master_if.master bus,
  output logic        busy
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
  , output logic      timeout_err
`endif
);

  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);

  state_e      state_d,   state_q;
  logic [7:0]  gap_cnt_d, gap_cnt_q;
  logic [7:0]  a_d,       a_q;
  logic [7:0]  b_d,       b_q;
  logic [15:0] res_d,     res_q;

  logic [7:0]  req_addr;
  logic [7:0]  req_data;
  logic        req_rd;
  logic        req_wr;
  logic [7:0]  rd_data;
  logic        op_fire;

`ifdef PORT_BUS_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_d, to_cnt_q;
  logic            timeout_err_d, timeout_err_q;
`endif

  // op_ready is held low while reset is asserted so nothing is accepted
  // during a multi-cycle reset.
  assign op_ready  = (state_q == S_IDLE) && !reset;
  assign op_fire   = op_valid && op_ready;
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign res_data  = res_q;

  // Next-state logic, then the bus access for the state being entered; the
  // access driver registers it so it appears on the bus in that state.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    req_addr  = ADDR_IDLE;
    req_data  = 8'h00;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (op_fire) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_WR_A;
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      S_WR_A:  state_d = S_WR_B;
      S_WR_B:  state_d = S_WR_GO;
      S_WR_GO: begin
        state_d   = S_GAP;
        gap_cnt_d = GAP_LOAD;
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = S_POLL;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      S_POLL: begin
        if (rd_data[DONE_BIT]) begin
          state_d = S_RD_MSB;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_RD_MSB: begin
        res_d[15:8] = rd_data;
        state_d     = S_RD_LSB;
      end
      S_RD_LSB: begin
        res_d[7:0] = rd_data;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PORT_BUS_MASTER_TIMEOUT_EN
    // The timeout window spans every GAP and POLL cycle of one operation; a
    // done seen on the final poll still wins over the timeout.
    if ((state_q == S_GAP) || (state_q == S_POLL)) begin
      if ((to_cnt_q == TO_LAST) &&
          !((state_q == S_POLL) && rd_data[DONE_BIT])) begin
        state_d       = S_RESP;
        res_d         = TIMEOUT_DATA;
        timeout_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif

    case (state_d)
      S_WR_A: begin
        req_addr = ADDR_A;
        req_data = a_d;
        req_wr   = 1'b1;
      end
      S_WR_B: begin
        req_addr = ADDR_B;
        req_data = b_d;
        req_wr   = 1'b1;
      end
      S_WR_GO: begin
        req_addr = ADDR_CTRL;
        req_data = START_CMD;
        req_wr   = 1'b1;
      end
      S_POLL: begin
        req_addr = ADDR_CTRL;
        req_rd   = 1'b1;
      end
      S_RD_MSB: begin
        req_addr = ADDR_A;
        req_rd   = 1'b1;
      end
      S_RD_LSB: begin
        req_addr = ADDR_B;
        req_rd   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= 8'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      res_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
    end
  end

`ifdef PORT_BUS_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

  port_bus_access #(
    .ADDR_IDLE (ADDR_IDLE)
  ) u_access (
    .clk      (clk),
    .reset    (reset),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .rd_data  (rd_data),
    .bus      (bus)
  );

endmodule

// File: tb/tb_port_bus_master.sv
// ---------------------------------------------------------------------------
// tb_port_bus_master
// Self-checking bench for port_bus_master with a behavioural signed-multiplier
// responder on the port bus and a bus monitor that logs writes and polls.
// Optional feature macro: PORT_BUS_MASTER_TIMEOUT_EN (adds the timeout test).
// ---------------------------------------------------------------------------
module tb_port_bus_master;
  import port_bus_master_pkg::*;

  localparam int POLL_GAP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
  logic        timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  port_bus_master_if bus_if();

  always #5 clk = ~clk;

  port_bus_master #(
    .POLL_GAP (POLL_GAP)
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (50)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .bus       (bus_if),
    .busy      (busy)
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  // Responder: signed 8x8 multiplier with done raised done_delay cycles after
  // start and held until the next start. Upper bits of the done register read
  // back as junk that the master must ignore.
  logic [7:0]  m_a = 8'h00;
  logic [7:0]  m_b = 8'h00;
  logic        m_done = 1'b0;
  int          done_cnt = 0;
  int          done_delay = 0;
  bit          done_never = 1'b0;
  logic [15:0] m_prod;
  logic [7:0]  resp_data;

  always_comb begin
    m_prod = $signed({{8{m_a[7]}}, m_a}) * $signed({{8{m_b[7]}}, m_b});
    case (bus_if.port_id)
      DEF_ADDR_A:    resp_data = m_prod[15:8];
      DEF_ADDR_B:    resp_data = m_prod[7:0];
      DEF_ADDR_CTRL: resp_data = {7'b1010101, m_done};
      default:       resp_data = 8'h00;
    endcase
  end
  assign bus_if.in_port = resp_data;

  always @(posedge clk) begin
    if (bus_if.write_strobe) begin
      case (bus_if.port_id)
        DEF_ADDR_A: m_a <= bus_if.out_port;
        DEF_ADDR_B: m_b <= bus_if.out_port;
        DEF_ADDR_CTRL: begin
          if (bus_if.out_port[0]) begin
            if (done_never) begin
              m_done <= 1'b0; done_cnt <= 0;
            end else if (done_delay == 0) begin
              m_done <= 1'b1; done_cnt <= 0;
            end else begin
              m_done <= 1'b0; done_cnt <= done_delay;
            end
          end
        end
        default: ;
      endcase
    end else if (done_cnt > 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) m_done <= 1'b1;
    end
  end

  // Bus monitor: write log, poll count and protocol-rule violations.
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t        wr_q[$];
  int         poll_cnt = 0;
  int         proto_bad = 0;
  logic       prev_stb = 1'b0;
  logic [7:0] prev_port = 8'h00;

  always @(posedge clk) begin
    if (bus_if.write_strobe) wr_q.push_back('{bus_if.port_id, bus_if.out_port});
    if (bus_if.read_strobe && bus_if.port_id == DEF_ADDR_CTRL) poll_cnt <= poll_cnt + 1;
    if (bus_if.write_strobe && bus_if.read_strobe) proto_bad <= proto_bad + 1;
    if ((bus_if.write_strobe || bus_if.read_strobe) && prev_stb && prev_port == bus_if.port_id)
      proto_bad <= proto_bad + 1;
    prev_stb  <= bus_if.write_strobe || bus_if.read_strobe;
    prev_port <= bus_if.port_id;
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int pa, pb;
    pa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    pb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    return 16'(pa * pb);
  endfunction

  // Runs one operation; lat = cycle (counted from the op handshake edge) in
  // which res_valid is first seen. Returns at the negedge after the result
  // handshake. Expired waits are counted as failures here.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int ddly,
                       input bit rr_high, output logic [15:0] res, output int lat);
    int n;
    res = 16'hxxxx;
    lat = -1;
    done_delay = ddly;
    @(negedge clk);
    wr_q.delete();
    poll_cnt = 0;
    op_a = a; op_b = b; op_valid = 1'b1; res_ready = rr_high;
    n = 0;
    while (!op_ready && n < 50) begin @(negedge clk); n++; end
    if (!op_ready) begin
      total++; bad++;
      $display("[TB] FAIL op_handshake: op_ready=%0b required 1", op_ready);
      op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 2000) begin @(negedge clk); n++; end
    if (!res_valid) begin
      total++; bad++;
      $display("[TB] FAIL res_wait: res_valid=%0b required 1 within 2000 cycles", res_valid);
      return;
    end
    lat = n;
    res = res_data;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = rr_high;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0; op_a = 8'h00; op_b = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (bus_if.port_id !== DEF_ADDR_IDLE || bus_if.out_port !== 8'h00 ||
        bus_if.write_strobe !== 1'b0 || bus_if.read_strobe !== 1'b0 ||
        op_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0000 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_vals: port_id=%h out=%h ws=%b rs=%b op_ready=%b res_valid=%b res_data=%h busy=%b required 00 00 0 0 0 0 0000 0",
               bus_if.port_id, bus_if.out_port, bus_if.write_strobe, bus_if.read_strobe,
               op_ready, res_valid, res_data, busy);
    end
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_timeout_err: got %b required 0", timeout_err);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_ready: op_ready=%b busy=%b required 1 0", op_ready, busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] r; int lat;
    do_op(8'h05, 8'hFD, 10, 1'b0, r, lat);
    total++;
    if (r !== 16'hFFF1) begin
      bad++; $display("[TB] FAIL basic_result: got %h required FFF1", r);
    end
    total++;
    if (wr_q.size() != 3) begin
      bad++; $display("[TB] FAIL basic_wr_count: got %0d required 3", wr_q.size());
    end else if (wr_q[0].addr !== 8'h80 || wr_q[0].data !== 8'h05 ||
                 wr_q[1].addr !== 8'h81 || wr_q[1].data !== 8'hFD ||
                 wr_q[2].addr !== 8'h82 || wr_q[2].data !== 8'h01) begin
      bad++;
      $display("[TB] FAIL basic_wr_trace: got %h:%h %h:%h %h:%h required 80:05 81:FD 82:01",
               wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data, wr_q[2].addr, wr_q[2].data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  av[2] = '{8'h80, 8'h7F};
    logic [15:0] ev[2] = '{16'h4000, 16'h3F01};
    logic [15:0] r; int lat;
    for (int i = 0; i < 2; i++) begin
      do_op(av[i], av[i], 2, 1'b1, r, lat);
      total++;
      if (r !== ev[i]) begin
        bad++; $display("[TB] FAIL b2b_result[%0d]: got %h required %h", i, r, ev[i]);
      end
      total++;
      if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL b2b_ready[%0d]: op_ready=%b res_valid=%b required 1 0", i, op_ready, res_valid);
      end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_latency();
    logic [15:0] r; int lat;
    do_op(8'h12, 8'h34, 0, 1'b0, r, lat);
    total++;
    if (lat != 7 + POLL_GAP) begin
      bad++; $display("[TB] FAIL latency: got %0d required %0d", lat, 7 + POLL_GAP);
    end
    total++;
    if (poll_cnt != 1) begin
      bad++; $display("[TB] FAIL poll_count: got %0d required 1", poll_cnt);
    end
    total++;
    if (r !== ref_mul(8'h12, 8'h34)) begin
      bad++; $display("[TB] FAIL latency_result: got %h required %h", r, ref_mul(8'h12, 8'h34));
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b; logic [15:0] r; int lat, d;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom); d = int'($urandom_range(0, 20));
      do_op(a, b, d, 1'b0, r, lat);
      total++;
      if (r !== ref_mul(a, b) || lat < 7 + POLL_GAP) begin
        bad++; $display("[TB] FAIL rand_result[%0d]: a=%h b=%h got %h lat=%0d required %h lat>=%0d",
                        i, a, b, r, lat, ref_mul(a, b), 7 + POLL_GAP);
      end
      total++;
      if (wr_q.size() != 3 || wr_q[0].data !== a || wr_q[1].data !== b) begin
        bad++; $display("[TB] FAIL rand_writes[%0d]: count=%0d required 3 with data %h %h", i, wr_q.size(), a, b);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] a, b; logic [15:0] e; int n;
    a = 8'($urandom); b = 8'($urandom); e = ref_mul(a, b);
    done_delay = 3; res_ready = 1'b0;
    @(negedge clk);
    op_a = a; op_b = b; op_valid = 1'b1;
    total++;
    if (op_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL stall_start: op_ready=%b required 1", op_ready);
      op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 500) begin @(negedge clk); n++; end
    total++;
    if (!res_valid) begin
      bad++; $display("[TB] FAIL stall_wait: res_valid=%b required 1", res_valid);
      return;
    end
    wr_q.delete();
    op_valid = 1'b1; op_a = ~a; op_b = ~b;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (res_valid !== 1'b1 || res_data !== e || bus_if.write_strobe !== 1'b0 ||
          bus_if.read_strobe !== 1'b0 || op_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall_hold[%0d]: res_valid=%b res_data=%h ws=%b rs=%b op_ready=%b busy=%b required 1 %h 0 0 0 1",
                 i, res_valid, res_data, bus_if.write_strobe, bus_if.read_strobe, op_ready, busy, e);
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    total++;
    if (wr_q.size() != 0) begin
      bad++; $display("[TB] FAIL stall_no_writes: got %0d writes required 0", wr_q.size());
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL stall_release: op_ready=%b res_valid=%b required 1 0", op_ready, res_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; int lat;
    done_delay = 30;
    @(negedge clk);
    op_a = 8'h3C; op_b = 8'hC3; op_valid = 1'b1;
    total++;
    if (op_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL rstmid_start: op_ready=%b required 1", op_ready);
      op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1 || bus_if.port_id !== DEF_ADDR_IDLE || bus_if.write_strobe !== 1'b0 || bus_if.read_strobe !== 1'b0) begin
      bad++; $display("[TB] FAIL rstmid_gap: busy=%b port_id=%h ws=%b rs=%b required 1 00 0 0",
                      busy, bus_if.port_id, bus_if.write_strobe, bus_if.read_strobe);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus_if.port_id !== DEF_ADDR_IDLE || bus_if.out_port !== 8'h00 ||
        bus_if.write_strobe !== 1'b0 || bus_if.read_strobe !== 1'b0 ||
        op_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0000 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_vals: port_id=%h out=%h ws=%b rs=%b op_ready=%b res_valid=%b res_data=%h busy=%b required 00 00 0 0 0 0 0000 0",
               bus_if.port_id, bus_if.out_port, bus_if.write_strobe, bus_if.read_strobe,
               op_ready, res_valid, res_data, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (op_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL rstmid_ready: op_ready=%b required 1", op_ready);
    end
    do_op(8'hF0, 8'h0F, 5, 1'b0, r, lat);
    total++;
    if (r !== ref_mul(8'hF0, 8'h0F) || wr_q.size() != 3) begin
      bad++; $display("[TB] FAIL rstmid_fresh: got %h writes=%0d required %h writes=3", r, wr_q.size(), ref_mul(8'hF0, 8'h0F));
    end
  endtask

`ifdef PORT_BUS_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] r; int lat;
    done_never = 1'b1;
    do_op(8'h11, 8'h22, 0, 1'b0, r, lat);
    done_never = 1'b0;
    total++;
    if (r !== 16'hDEAD || timeout_err !== 1'b1) begin
      bad++; $display("[TB] FAIL timeout_result: got %h err=%b required DEAD 1", r, timeout_err);
    end
    do_op(8'h02, 8'h03, 1, 1'b0, r, lat);
    total++;
    if (r !== 16'h0006 || timeout_err !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_clear: got %h err=%b required 0006 0", r, timeout_err);
    end
  endtask
`endif

  task automatic test_protocol();
    total++;
    if (proto_bad != 0) begin
      bad++; $display("[TB] FAIL bus_protocol: got %0d violations required 0", proto_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_latency();
    test_random();
    test_stall();
    test_reset_mid();
`ifdef PORT_BUS_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
